// File: rtl/fsm_pkg.sv
// Shared types for the job driver and its IDLE/BUSY/WAITING responder.
// Holds the responder state encoding, the driver state enum and default parameters.
package fsm_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE    = 2'b00,
        RSP_BUSY    = 2'b01,
        RSP_WAITING = 2'b10
    } rsp_state_e;

    typedef enum logic [2:0] {
        D_IDLE,
        D_START,
        D_RUN,
        D_HOLD,
        D_RESUME,
        D_FINISH
    } drv_state_e;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int LEN_W_DEFAULT   = 8;

endpackage

// File: rtl/fsm_ack_timer.sv
// Acknowledge timer: counts enabled cycles since the last clear.
// expired is high while the count sits at TIMEOUT-1, i.e. on the TIMEOUT-th enabled cycle.
module fsm_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Independent of enable so the caller can gate it without a combinational loop.
    assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fsm_job_driver.sv
// Job driver: issues start/wait/finish to the responder and counts beats per job.
// Optional FSM_JOB_DRIVER_STATS_EN adds completed-job and stall-cycle counters.
module fsm_job_driver
    import fsm_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_job_valid,
    output logic             o_job_ready,
    input  logic [LEN_W-1:0] i_job_len,
    input  logic             i_stall,
    input  logic [1:0]       i_state,
    output logic             o_start,
    output logic             o_wait,
    output logic             o_finish,
    output logic             o_beat,
    output logic             o_done,
    output logic             o_error
`ifdef FSM_JOB_DRIVER_STATS_EN
    ,
    output logic [15:0]      o_jobs_done,
    output logic [15:0]      o_stall_cycles
`endif
);

    drv_state_e       state_reg, state_next;
    logic [LEN_W-1:0] remain_reg, remain_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic             tmr_clear, tmr_enable, tmr_expired;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= D_IDLE;
            remain_reg <= '0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        done_next   = 1'b0;
        error_next  = error_reg;
        tmr_enable  = 1'b0;
        case (state_reg)
            D_IDLE: begin
                if (i_job_valid) begin
                    if (i_job_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        remain_next = i_job_len;
                        state_next  = D_START;
                    end
                end
            end
            D_START, D_RESUME: begin
                tmr_enable = 1'b1;
                if (i_state == RSP_BUSY) begin
                    state_next = D_RUN;
                end else if (tmr_expired) begin
                    state_next  = D_IDLE;
                    error_next  = 1'b1;
                    remain_next = '0;
                end
            end
            D_RUN: begin
                // Stall wins even on the last beat, so the job parks in HOLD first.
                if (i_stall) begin
                    state_next = D_HOLD;
                end else begin
                    remain_next = remain_reg - LEN_W'(1);
                    if (remain_reg == LEN_W'(1)) begin
                        state_next = D_FINISH;
                    end
                end
            end
            D_HOLD: begin
                tmr_enable = (i_state != RSP_WAITING);
                if (i_state == RSP_WAITING) begin
                    if (!i_stall) begin
                        state_next = D_RESUME;
                    end
                end else if (tmr_expired) begin
                    state_next  = D_IDLE;
                    error_next  = 1'b1;
                    remain_next = '0;
                end
            end
            D_FINISH: begin
                tmr_enable = 1'b1;
                if (i_state == RSP_IDLE) begin
                    done_next  = 1'b1;
                    state_next = D_IDLE;
                end else if (tmr_expired) begin
                    state_next  = D_IDLE;
                    error_next  = 1'b1;
                    remain_next = '0;
                end
            end
            default: begin
                state_next = D_IDLE;
            end
        endcase
    end

    // Every state change restarts the acknowledge window.
    assign tmr_clear = (state_next != state_reg);

    fsm_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    assign o_job_ready = (state_reg == D_IDLE);
    assign o_start     = (state_reg == D_START) || (state_reg == D_RESUME);
    assign o_wait      = (state_reg == D_HOLD);
    assign o_finish    = (state_reg == D_FINISH);
    assign o_beat      = (state_reg == D_RUN) && !i_stall;
    assign o_done      = done_reg;
    assign o_error     = error_reg;

`ifdef FSM_JOB_DRIVER_STATS_EN
    logic [15:0] jobs_done_reg;
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            jobs_done_reg    <= '0;
            stall_cycles_reg <= '0;
        end else begin
            if (done_next) begin
                jobs_done_reg <= jobs_done_reg + 16'd1;
            end
            if ((state_reg == D_HOLD) && (stall_cycles_reg != 16'hFFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            end
        end
    end

    assign o_jobs_done    = jobs_done_reg;
    assign o_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_fsm_job_driver.sv
// Scoreboard bench for fsm_job_driver with a behavioural responder.
// Stimulus queues hand-computed job profiles; a negedge monitor measures and compares them.
module tb_fsm_job_driver;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        int lat;
        int beats;
        int starts;
        int waits;
        int fins;
        int done;
        int err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic             stall;
    logic [1:0]       rsp_state;
    logic             start_cmd, wait_cmd, finish_cmd, beat, done, error;
`ifdef FSM_JOB_DRIVER_STATS_EN
    logic [15:0]      jobs_done, stall_cycles;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic stuck;
    logic [1:0] resp_q, resp_next;

    fsm_job_driver #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_job_valid    (job_valid),
        .o_job_ready    (job_ready),
        .i_job_len      (job_len),
        .i_stall        (stall),
        .i_state        (rsp_state),
        .o_start        (start_cmd),
        .o_wait         (wait_cmd),
        .o_finish       (finish_cmd),
        .o_beat         (beat),
        .o_done         (done),
        .o_error        (error)
`ifdef FSM_JOB_DRIVER_STATS_EN
        ,
        .o_jobs_done    (jobs_done),
        .o_stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder that acknowledges each command in the same cycle it is issued.
    always_comb begin
        resp_next = resp_q;
        if (start_cmd)       resp_next = 2'b01;
        else if (wait_cmd)   resp_next = 2'b10;
        else if (finish_cmd) resp_next = 2'b00;
        rsp_state = stuck ? 2'b00 : resp_next;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)         resp_q <= 2'b00;
        else if (!stuck) resp_q <= resp_next;
    end

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: measures each accepted job until o_done or a fresh o_error.
    initial begin
        bit   active = 0;
        bit   ovl = 0, rdy = 0, err0 = 0;
        int   cnt = 0, nb = 0, ns = 0, nw = 0, nf = 0, jid = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else begin
                if (active) begin
                    cnt++;
                    if (done || (error && !err0)) begin
                        active = 0;
                        if (exp_q.size() == 0) begin
                            check($sformatf("job%0d_unexpected", jid), 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("job%0d_latency", jid), cnt, e.lat);
                            check($sformatf("job%0d_beats", jid), nb, e.beats);
                            check($sformatf("job%0d_start_cycles", jid), ns, e.starts);
                            check($sformatf("job%0d_wait_cycles", jid), nw, e.waits);
                            check($sformatf("job%0d_finish_cycles", jid), nf, e.fins);
                            check($sformatf("job%0d_done", jid), int'(done), e.done);
                            check($sformatf("job%0d_error", jid), int'(error), e.err);
                            check($sformatf("job%0d_cmd_overlap", jid), int'(ovl), 0);
                            check($sformatf("job%0d_ready_in_job", jid), int'(rdy), 0);
                            $display("[TB] job%0d lat=%0d beats=%0d starts=%0d waits=%0d fins=%0d done=%0d err=%0d",
                                     jid, cnt, nb, ns, nw, nf, done, error);
                        end
                        jid++;
                    end else begin
                        nb += int'(beat);
                        ns += int'(start_cmd);
                        nw += int'(wait_cmd);
                        nf += int'(finish_cmd);
                        if (int'(start_cmd) + int'(wait_cmd) + int'(finish_cmd) > 1) ovl = 1;
                        if (job_ready) rdy = 1;
                    end
                end
                if (!active && job_ready && job_valid) begin
                    active = 1;
                    cnt = 0; nb = 0; ns = 0; nw = 0; nf = 0;
                    ovl = 0; rdy = 0; err0 = error;
                end
            end
        end
    end

    task automatic run_job(input int len, input int stall_after, input int stall_len,
                           input bit stuck_rsp, input exp_t e);
        int b;
        bit seen;
        exp_q.push_back(e);
        stuck     = stuck_rsp;
        job_len   = LEN_W'(len);
        job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
        if (stall_len > 0) begin
            b = 0;
            for (int i = 0; i < 100 && b < stall_after; i++) begin
                @(negedge clk);
                if (beat) b++;
            end
            @(posedge clk);
            #1 stall = 1'b1;
            repeat (stall_len) @(posedge clk);
            #1 stall = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done || error) seen = 1;
        end
        check($sformatf("job_len%0d_completed", len), int'(seen), 1);
        @(posedge clk);
        #1 stuck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1; job_valid = 1'b0; job_len = '0; stall = 1'b0; stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({job_ready, start_cmd, wait_cmd, finish_cmd, beat, done, error}),
              int'(7'b1000000));
`ifdef FSM_JOB_DRIVER_STATS_EN
        check("reset_jobs_done", int'(jobs_done), 0);
        check("reset_stall_cycles", int'(stall_cycles), 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // len=3, no stall: start, 3 beats, finish, done visible 6 samples after accept.
        run_job(3, 0, 0, 0, '{lat: 6, beats: 3, starts: 1, waits: 0, fins: 1, done: 1, err: 0});
        // len=4, 3 stall cycles after beat 2: 3 HOLD cycles, one resume.
        run_job(4, 2, 3, 0, '{lat: 12, beats: 4, starts: 2, waits: 3, fins: 1, done: 1, err: 0});
        // len=0: immediate done, no commands.
        run_job(0, 0, 0, 0, '{lat: 1, beats: 0, starts: 0, waits: 0, fins: 0, done: 1, err: 0});
        // Responder stuck at IDLE: 16 start cycles then sticky error.
        run_job(2, 0, 0, 1, '{lat: 17, beats: 0, starts: 16, waits: 0, fins: 0, done: 0, err: 1});

        repeat (5) @(posedge clk);
        #1;
        check("error_sticky", int'(error), 1);
        check("ready_after_timeout", int'(job_ready), 1);
        check("start_dropped_after_timeout", int'(start_cmd), 0);
        $display("[TB] after timeout error=%0d ready=%0d start=%0d", error, job_ready, start_cmd);

        // Reset in D_RUN after two beats of a len=7 job (remain=5).
        job_len = 8'd7; job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
        b = 0;
        for (int i = 0; i < 50 && b < 2; i++) begin
            @(negedge clk);
            if (beat) b++;
        end
        check("beats_before_reset", b, 2);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({job_ready, start_cmd, wait_cmd, finish_cmd, beat, done, error}),
              int'(7'b1000000));
        $display("[TB] mid-job reset ready=%0d start=%0d beat=%0d error=%0d", job_ready, start_cmd, beat, error);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(1, 0, 0, 0, '{lat: 4, beats: 1, starts: 1, waits: 0, fins: 1, done: 1, err: 0});
        run_job(4, 2, 3, 0, '{lat: 12, beats: 4, starts: 2, waits: 3, fins: 1, done: 1, err: 0});
        run_job(2, 1, 4, 0, '{lat: 11, beats: 2, starts: 2, waits: 4, fins: 1, done: 1, err: 0});

`ifdef FSM_JOB_DRIVER_STATS_EN
        check("stats_jobs_done", int'(jobs_done), 3);
        check("stats_stall_cycles", int'(stall_cycles), 7);
        $display("[TB] stats jobs_done=%0d stall_cycles=%0d", jobs_done, stall_cycles);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
